// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
// Purpose: response-owner encoding, data-port size masks and the response record.
// Ports: none (package).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Unshifted size masks presented on d_be
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // One outstanding response: who gets it, which byte lane it started at,
   // and whether it is an alignment-error completion instead of real data
   typedef struct packed {
      owner_t     owner;
      logic [1:0] offset;
      logic       err;
   } resp_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, data and SRAM signal bundle for the arbiter
// Purpose: groups the fetch port, load/store port and SRAM macro port.
// Ports (signals): if_req/if_addr/if_gnt/if_rvalid/if_rdata (fetch),
//   d_req/d_we/d_be/d_addr/d_wdata/d_gnt/d_rvalid/d_rdata/d_err (data),
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata (SRAM).
// Modports: slave = arbiter side, master = core + SRAM side.
interface unified_mem_arbiter_if #(
   parameter int SIZE = 12
);
   logic            if_req;
   logic [31:0]     if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [31:0]     if_rdata;

   logic            d_req;
   logic            d_we;
   logic [3:0]      d_be;
   logic [31:0]     d_addr;
   logic [31:0]     d_wdata;
   logic            d_gnt;
   logic            d_rvalid;
   logic [31:0]     d_rdata;
   logic            d_err;

   logic            mem_en;
   logic [3:0]      mem_we;
   logic [SIZE-3:0] mem_addr;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/unified_mem_arbiter_lane_align.sv
// rtl/unified_mem_arbiter_lane_align.sv - byte-lane shifter and alignment check for stores/loads
// Purpose: moves right-justified store data and size mask onto the lanes selected
//   by the low address bits, and flags accesses that straddle a word.
// Ports: be_i (unshifted size mask), off_i (addr[1:0]), wdata_i (right-justified data),
//   be_o (lane byte enables), wdata_o (lane data), misaligned_o.
module lane_align
   import mem_arb_pkg::*;
(
   input  logic [3:0]  be_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   always_comb begin
      be_o         = be_i << off_i;
      wdata_o      = wdata_i << {off_i, 3'b000};
      misaligned_o = 1'b0;
      if (be_i == BE_HALF && off_i[0]) begin
         misaligned_o = 1'b1;
      end
      if (be_i == BE_WORD && off_i != 2'b00) begin
         misaligned_o = 1'b1;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port SRAM shared by instruction fetch and load/store
// Purpose: data-first arbitration with a fetch starvation guard, lane alignment of
//   store data, right-justification of load data, 1-cycle response pipeline.
// Ports: clk, rst (sync, active-high), bus (unified_mem_arbiter_if.slave: fetch port,
//   data port and SRAM port).
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int SIZE       = 12,
   parameter int STARVE_MAX = 4
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_q, starve_d;
   resp_t         resp_q, resp_d;

   logic        if_gnt, d_gnt, fetch_pri, d_mis;
   logic [3:0]  be_sh;
   logic [31:0] wdata_sh;
   logic        unused_addr_bits;

   lane_align u_align (
      .be_i         (bus.d_be),
      .off_i        (bus.d_addr[1:0]),
      .wdata_i      (bus.d_wdata),
      .be_o         (be_sh),
      .wdata_o      (wdata_sh),
      .misaligned_o (d_mis)
   );

   // Upper address bits beyond the macro and the fetch lane offset are don't-care
   assign unused_addr_bits = ^{bus.if_addr[31:SIZE], bus.if_addr[1:0], bus.d_addr[31:SIZE]};

   always_comb begin
      fetch_pri = (starve_q == CW'(STARVE_MAX));
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if (!rst) begin
         if_gnt = bus.if_req && (!bus.d_req || fetch_pri);
         d_gnt  = bus.d_req && !if_gnt;
      end

      // Counts only cycles where fetch is actually waiting
      starve_d = starve_q;
      if (!bus.if_req || if_gnt) begin
         starve_d = '0;
      end else if (!fetch_pri) begin
         starve_d = starve_q + CW'(1);
      end

      resp_d = '{owner: OWN_NONE, offset: 2'b00, err: 1'b0};
      if (if_gnt) begin
         resp_d = '{owner: OWN_IF, offset: 2'b00, err: 1'b0};
      end else if (d_gnt) begin
         resp_d = '{owner: OWN_D, offset: bus.d_addr[1:0], err: d_mis};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         resp_q   <= '{owner: OWN_NONE, offset: 2'b00, err: 1'b0};
      end else begin
         starve_q <= starve_d;
         resp_q   <= resp_d;
      end
   end

   // Misaligned data requests are acknowledged but never touch the SRAM
   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.mem_en    = if_gnt || (d_gnt && !d_mis);
   assign bus.mem_we    = (d_gnt && bus.d_we && !d_mis) ? be_sh : 4'b0000;
   assign bus.mem_wdata = (d_gnt && bus.d_we && !d_mis) ? wdata_sh : 32'h0;
   assign bus.mem_addr  = if_gnt ? bus.if_addr[SIZE-1:2] : bus.d_addr[SIZE-1:2];

   // Response stage; gated by rst so a response in flight when reset rises is dropped
   assign bus.if_rvalid = !rst && (resp_q.owner == OWN_IF);
   assign bus.d_rvalid  = !rst && (resp_q.owner == OWN_D);
   assign bus.d_err     = bus.d_rvalid && resp_q.err;
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
   assign bus.d_rdata   = (bus.d_rvalid && !resp_q.err) ?
                          (bus.mem_rdata >> {resp_q.offset, 3'b000}) : 32'h0;

endmodule
